// File: rtl/vga_fb.sv
// 160x120x12 framebuffer feeding the VGA controller, each stored pixel shown as a 4x4 block.
// Single-pixel writes via valid/ready, whole-buffer fill engine, self-clear to black after reset.
module vga_fb #(
  parameter int unsigned FB_W         = 160,
  parameter int unsigned FB_H         = 120,
  parameter logic [11:0] BORDER_COLOR = 12'h000
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic        rdn,
  output logic [11:0] d_in,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_x,
  input  logic [6:0]  wr_y,
  input  logic [11:0] wr_color,
  input  logic        fill_start,
  input  logic [11:0] fill_color,
  output logic        busy
);

  localparam int unsigned Words    = FB_W * FB_H;
  localparam logic [14:0] LastAddr = 15'(Words - 1);
  localparam logic [7:0]  XLim     = 8'(FB_W);
  localparam logic [6:0]  YLim     = 7'(FB_H);

  typedef enum logic {StIdle, StFill} state_e;

  state_e      state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic [11:0] fill_col_q, fill_col_d;
  logic [11:0] d_in_q, d_in_d;

  logic [11:0] mem [Words];

  logic [7:0]  rd_x;
  logic [6:0]  rd_y;
  logic [14:0] rd_addr;
  logic [14:0] px_addr;
  logic        mem_we;
  logic [14:0] mem_waddr;
  logic [11:0] mem_wdata;

  // y*160 + x as shifts: (y<<7) + (y<<5) + x
  function automatic logic [14:0] lin_addr(input logic [6:0] y, input logic [7:0] x);
    return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
  endfunction

  always_comb begin
    rd_x    = col_addr[9:2];
    rd_y    = row_addr[8:2];
    rd_addr = lin_addr(rd_y, rd_x);
    px_addr = lin_addr(wr_y, wr_x);
    d_in_d  = BORDER_COLOR;
    if (!rdn && (rd_x < XLim) && (rd_y < YLim)) begin
      d_in_d = mem[rd_addr];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_col_d = fill_col_q;
    mem_we     = 1'b0;
    mem_waddr  = px_addr;
    mem_wdata  = wr_color;
    unique case (state_q)
      StIdle: begin
        if (fill_start) begin
          state_d    = StFill;
          cnt_d      = '0;
          fill_col_d = fill_color;
        end else if (wr_valid && (wr_x < XLim) && (wr_y < YLim)) begin
          mem_we = 1'b1;
        end
      end
      StFill: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = fill_col_q;
        cnt_d     = cnt_q + 15'd1;
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // Reset lands in StFill so the buffer clears itself to black.
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      state_q    <= StFill;
      cnt_q      <= '0;
      fill_col_q <= 12'h000;
      d_in_q     <= BORDER_COLOR;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_col_q <= fill_col_d;
      d_in_q     <= d_in_d;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign d_in     = d_in_q;
  assign busy     = (state_q == StFill);
  assign wr_ready = (state_q == StIdle) && !fill_start;

endmodule

// File: tb/tb_vga_fb.sv
// Randomized bench for vga_fb against a behavioural framebuffer model.
module tb_vga_fb;

  localparam logic [11:0] Border = 12'h5A5;
  localparam int          NWords = 160 * 120;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  row_addr = '0;
  logic [9:0]  col_addr = '0;
  logic        rdn = 1'b1;
  logic [11:0] d_in;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  wr_x = '0;
  logic [6:0]  wr_y = '0;
  logic [11:0] wr_color = '0;
  logic        fill_start = 1'b0;
  logic [11:0] fill_color = '0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  vga_fb #(
    .FB_W(160),
    .FB_H(120),
    .BORDER_COLOR(Border)
  ) dut (
    .vga_clk(clk),
    .rst(rst),
    .row_addr(row_addr),
    .col_addr(col_addr),
    .rdn(rdn),
    .d_in(d_in),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_x(wr_x),
    .wr_y(wr_y),
    .wr_color(wr_color),
    .fill_start(fill_start),
    .fill_color(fill_color),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: image array plus "fill in progress at position p".
  logic [11:0] ref_mem [NWords];
  bit          ref_ok  [NWords];
  bit          fill_act = 1'b1;
  int          fill_pos = 0;
  logic [11:0] fill_c   = 12'h000;
  logic [11:0] exp_d    = Border;
  bit          exp_ok   = 1'b1;

  always begin : model_and_compare
    int x, y;
    @(posedge clk);
    if (rst) begin
      fill_act = 1'b1;
      fill_pos = 0;
      fill_c   = 12'h000;
      exp_d    = Border;
      exp_ok   = 1'b1;
    end else begin
      x = int'(col_addr) / 4;
      y = int'(row_addr) / 4;
      if (!rdn && x < 160 && y < 120) begin
        exp_d  = ref_mem[y * 160 + x];
        exp_ok = ref_ok[y * 160 + x];
      end else begin
        exp_d  = Border;
        exp_ok = 1'b1;
      end
      if (fill_act) begin
        ref_mem[fill_pos] = fill_c;
        ref_ok[fill_pos]  = 1'b1;
        fill_pos++;
        if (fill_pos == NWords) fill_act = 1'b0;
      end else if (fill_start) begin
        fill_act = 1'b1;
        fill_pos = 0;
        fill_c   = fill_color;
      end else if (wr_valid && int'(wr_x) < 160 && int'(wr_y) < 120) begin
        ref_mem[int'(wr_y) * 160 + int'(wr_x)] = wr_color;
        ref_ok[int'(wr_y) * 160 + int'(wr_x)]  = 1'b1;
      end
    end
    #1;
    chk("busy", 32'(busy), 32'(fill_act));
    chk("wr_ready", 32'(wr_ready), 32'(!fill_act && !fill_start));
    if (exp_ok) chk("d_in", 32'(d_in), 32'(exp_d));
  end

  task automatic rand_read();
    row_addr = 9'($urandom_range(0, 524));
    col_addr = 10'($urandom_range(0, 799));
    rdn      = 1'($urandom_range(0, 1));
  endtask

  // Counts edges until busy drops; pulses fill_start on edge pulse_at+1.
  task automatic run_fill(input int pulse_at, output int n);
    n = 0;
    while (n < 25000) begin
      @(posedge clk);
      #2;
      n++;
      fill_start = (n == pulse_at);
      if (!busy) break;
      rand_read();
    end
    fill_start = 1'b0;
  endtask

  task automatic rd(input int r, input int c, input logic [11:0] exp, input string nm);
    @(negedge clk);
    row_addr = 9'(r);
    col_addr = 10'(c);
    rdn      = 1'b0;
    @(posedge clk);
    #2;
    chk(nm, 32'(d_in), 32'(exp));
  endtask

  task automatic wr(input int x, input int y, input logic [11:0] c);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_x     = 8'(x);
    wr_y     = 7'(y);
    wr_color = c;
    #1;
    chk("wr_handshake", 32'(wr_ready), 32'd1);
    @(posedge clk);
    #2;
    wr_valid = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_d_in", 32'(d_in), 32'(Border));

    @(negedge clk);
    rst = 1'b0;
    run_fill(-1, n);
    chk("reset_fill_len", 32'(n), 32'd19200);
    chk("ready_after_clear", 32'(wr_ready), 32'd1);
    rd(0, 0, 12'h000, "clear_first");
    rd(479, 639, 12'h000, "clear_last");

    wr(160, 0, 12'hFFF);
    wr(0, 120, 12'hEEE);
    rd(0, 0, 12'h000, "oor_addr0");
    rd(479, 639, 12'h000, "oor_addr_last");

    wr(10, 5, 12'hF0A);
    for (int r = 20; r < 24; r++) begin
      for (int c = 40; c < 44; c++) rd(r, c, 12'hF0A, "px_block");
    end
    rd(20, 44, 12'h000, "px_right");
    rd(19, 40, 12'h000, "px_above");
    rd(10, 700, Border, "hblank");
    rd(500, 10, Border, "vblank");
    @(negedge clk);
    row_addr = 9'd20;
    col_addr = 10'd40;
    rdn      = 1'b1;
    @(posedge clk);
    #2;
    chk("rdn_high", 32'(d_in), 32'(Border));

    // Random writes/reads, half concentrated in a small window so reads hit writes.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      wr_valid = 1'($urandom_range(0, 1));
      wr_color = 12'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        wr_x     = 8'($urandom_range(0, 7));
        wr_y     = 7'($urandom_range(0, 7));
        row_addr = 9'($urandom_range(0, 31));
        col_addr = 10'($urandom_range(0, 31));
        rdn      = 1'b0;
      end else begin
        wr_x = 8'($urandom_range(0, 170));
        wr_y = 7'($urandom_range(0, 125));
        rand_read();
      end
    end
    @(negedge clk);
    wr_valid = 1'b0;

    fill_start = 1'b1;
    fill_color = 12'h0F0;
    wr_valid   = 1'b1;
    wr_x       = 8'd3;
    wr_y       = 7'd3;
    wr_color   = 12'hABC;
    #1;
    chk("prio_ready", 32'(wr_ready), 32'd0);
    @(posedge clk);
    #2;
    fill_start = 1'b0;
    wr_valid   = 1'b0;
    fill_color = 12'h777;
    chk("busy_rise", 32'(busy), 32'd1);
    run_fill(100, n);
    chk("fill_len_restart_ignored", 32'(n), 32'd19200);
    rd(15, 15, 12'h0F0, "fill_px33");
    rd(0, 0, 12'h0F0, "fill_first");
    rd(479, 639, 12'h0F0, "fill_last");

    @(negedge clk);
    fill_start = 1'b1;
    fill_color = 12'h123;
    @(posedge clk);
    #2;
    fill_start = 1'b0;
    for (int i = 1; i < 5000; i++) begin
      @(posedge clk);
      #2;
      rand_read();
    end
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_d_in", 32'(d_in), 32'(Border));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_fill(-1, n);
    chk("midrst_fill_len", 32'(n), 32'd19200);
    rd(0, 0, 12'h000, "midrst_first");
    rd(479, 639, 12'h000, "midrst_last");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_fb.md
# vga_fb

Framebuffer that sits directly upstream of the VGA timing controller. It stores a 160×120 image of 12-bit pixels and returns them on `d_in` for the controller's `row_addr`/`col_addr`/`rdn` requests, scaling each stored pixel to a 4×4 block on the 640×480 screen. Game logic writes single pixels through a valid/ready port or clears the whole buffer with a fill command. The block clears itself to black after reset.

## Interface

- `FB_W`, default 160: stored image width in pixels. Equals 640/4.
- `FB_H`, default 120: stored image height in lines. Equals 480/4.
- `BORDER_COLOR`, default 12'h000: value driven on `d_in` for non-visible requests.

- `vga_clk` in 1: the single 25 MHz clock; all logic is on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `row_addr` in 9: screen row from the VGA controller, 0–479 while visible.
- `col_addr` in 10: screen column from the VGA controller, 0–639 while visible.
- `rdn` in 1: read request from the VGA controller, active low.
- `d_in` out 12: pixel to the VGA controller, format bbbb_gggg_rrrr.
- `wr_valid` in 1: pixel write request.
- `wr_ready` out 1: write accepted this cycle when `wr_valid` is also high.
- `wr_x` in 8: write column, 0–159.
- `wr_y` in 7: write row, 0–119.
- `wr_color` in 12: write pixel, bbbb_gggg_rrrr.
- `fill_start` in 1: one-cycle pulse that starts filling the whole buffer.
- `fill_color` in 12: fill value, sampled on the cycle `fill_start` is taken.
- `busy` out 1: high while a fill is in progress.

## Operation

- **Storage.** Simple dual-port RAM, `FB_W*FB_H` = 19200 words of 12 bits, with a synchronous read port. RAM contents are not reset.
- **Linear address.** `addr = y*160 + x` (15 bits), computed as `(y<<7)+(y<<5)+x` with no multiplier.
- **Read path.**
  - `x = col_addr[9:2]`, `y = row_addr[8:2]`.
  - The RAM read is issued every cycle.
  - The `d_in` register loads `RAM[addr]` when the `rdn` sampled on the same edge was 0 and `x<160` and `y<120`. Otherwise it loads `BORDER_COLOR`.
- **State machine.** Two states, IDLE and FILL.
  - IDLE:
    - `wr_ready = !fill_start`, so `fill_start` takes priority over a write in the same cycle.
    - A write handshake is `wr_valid && wr_ready`. In-range coordinates write `RAM[addr(wr_x,wr_y)] <= wr_color`.
    - A handshake with `wr_x>=160` or `wr_y>=120` is accepted and dropped: no RAM write.
    - `fill_start` latches `fill_color`, clears the fill counter and moves to FILL.
  - FILL:
    - `wr_ready=0`, `busy=1`.
    - Each cycle writes the latched colour at counter address, then increments the counter.
    - After writing address 19199, return to IDLE.
    - `fill_start` is ignored in FILL and does not restart the fill.
- **Write port arbitration.** The write port is owned by the fill engine in FILL and by `wr_*` in IDLE. There is never a conflict.
- **Reads during FILL.** The read port is independent and keeps serving the display. A partially filled image is visible.

## Timing

- **Reset values** (while `rst` high):
  - state=FILL, counter=0, fill colour register=12'h000.
  - `busy=1`, `wr_ready=0`, `d_in=BORDER_COLOR`.
- **After reset.** The first edge after `rst` falls writes address 0. `busy` falls after exactly 19200 write cycles. From then on the buffer is all 12'h000.
- **Reset mid-operation.** A reset during a fill restarts from address 0 with colour 0. The fill colour in progress is discarded. A pending write is dropped.
- **Read latency.** One cycle: the `d_in` captured on edge k+1 corresponds to `row_addr`/`col_addr`/`rdn` present at edge k.
  - The VGA controller samples `d_in` one edge later, so the image is displayed one screen pixel right of nominal.
  - The first visible column of each line shows `BORDER_COLOR`.
- **Write latency.** The RAM is updated on the handshake edge. A read of the same address on that edge returns the old data; the next read returns the new data.
- **Fill duration.** Exactly 19200 cycles, with `busy` high throughout. A full screen redraw is 420000 cycles, so a fill completes in under 5% of a frame.
- **`busy` and `wr_ready`.** Both are registered-state decodes. `wr_ready` additionally depends combinationally on `fill_start`.

## Test plan

- **Reset clear.** Pulse `rst`, then hold idle. Require `busy=1` for 19200 cycles then 0, and `wr_ready=1` afterwards. Reading row 0/col 0 and row 479/col 639 returns 12'h000.
- **Pixel write/read.** Write (`wr_x`=10, `wr_y`=5, 12'hF0A). Drive rows 20–23 and cols 40–43 with `rdn=0`; each gives `d_in=12'hF0A` one cycle later. Col 44 gives 12'h000.
- **Out of range and non-visible.** A write at (160, 0) or (0, 120) completes its handshake and leaves addresses 0 and 19199 unchanged. With `rdn=1`, `d_in=BORDER_COLOR` one cycle later regardless of address.
- **Fill priority.** In IDLE, assert `fill_start` (`fill_color`=12'h0F0) and `wr_valid` together. Require `wr_ready=0` that cycle and no pixel write. `busy` rises next cycle, and after 19200 cycles every sampled pixel reads 12'h0F0.
- **Fill restart ignored and mid-fill reset.** Pulse `fill_start` at fill cycle 100: `busy` still falls at cycle 19200. Assert `rst` at fill cycle 5000: the fill restarts from 0 with 12'h000 and completes 19200 cycles after release.
